// File: rtl/cmm_pkg.sv
// rtl/cmm_pkg.sv - shared types and defaults for the CMM frame sequencer
package cmm_pkg;

  localparam int COLUMNS_DEF  = 256;
  localparam int SAMPLE_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } state_t;

  // One column beat as seen by the CMM: index 0 is channel 0.
  typedef logic [3:0][SAMPLE_W_DEF-1:0] beat_t;

endpackage

// File: rtl/cmm_seq_skid.sv
// rtl/cmm_seq_skid.sv - 2-entry skid buffer between the sample buffer read and s_axis
module cmm_seq_skid #(
  parameter int W = 130
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         almost_full
);

  logic [W-1:0] mem0, mem1;
  logic [1:0]   count;
  logic [2:0]   nxt_count;
  logic         do_pop;

  assign valid     = (count != 2'd0);
  assign dout      = mem0;
  assign do_pop    = pop && valid;
  assign nxt_count = {1'b0, count} + {2'b0, push} - {2'b0, do_pop};
  // A read issued now lands next cycle, so stop once that landing could overflow.
  assign almost_full = (nxt_count >= 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      count <= nxt_count[1:0];
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= din;
          else               mem1 <= din;
        end
        2'b01: mem0 <= mem1;
        2'b11: begin
          if (count == 2'd1) begin
            mem0 <= din;
          end else begin
            mem0 <= mem1;
            mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cmm_frame_sequencer.sv
// rtl/cmm_frame_sequencer.sv - streams one covariance frame into the CMM and waits for its result
module cmm_frame_sequencer
  import cmm_pkg::*;
#(
  parameter int COLUMNS  = COLUMNS_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ADDR_W   = $clog2(COLUMNS),
  parameter int TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [15:0]         frame_count,
  output logic                buf_rd_en,
  output logic [ADDR_W-1:0]   buf_rd_addr,
  input  logic [SAMPLE_W-1:0] buf_rd_data_0,
  input  logic [SAMPLE_W-1:0] buf_rd_data_1,
  input  logic [SAMPLE_W-1:0] buf_rd_data_2,
  input  logic [SAMPLE_W-1:0] buf_rd_data_3,
  output logic                s_axis_tvalid,
  input  logic                s_axis_tready,
  output logic                s_axis_tlast,
  output logic                s_axis_tuser,
  output logic [SAMPLE_W-1:0] channel_0_base,
  output logic [SAMPLE_W-1:0] channel_1_base,
  output logic [SAMPLE_W-1:0] channel_2_base,
  output logic [SAMPLE_W-1:0] channel_3_base,
  input  logic                m_axis_dout_tvalid,
  input  logic                m_axis_dout_tlast,
  output logic                m_axis_dout_tready,
  output logic                result_latch
);

  localparam int BEAT_W = 4 * SAMPLE_W + 2;
  localparam int TMO_W  = $clog2(TIMEOUT) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLUMNS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, rd_addr;
  logic              reads_done, rd_pending, pend_user, pend_last, dout_ready_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              start_acc, beat_acc, skid_afull, skid_valid;
  logic [BEAT_W-1:0] skid_in, skid_out;
  logic              unused_trace;

  // Result tlast carries no sequencing meaning here; it is only useful on a trace.
  assign unused_trace = m_axis_dout_tlast;

  assign start_acc = (state == IDLE) && start && !reset;
  assign beat_acc  = skid_valid && s_axis_tready;
  assign skid_in   = {pend_user, pend_last, buf_rd_data_3, buf_rd_data_2,
                      buf_rd_data_1, buf_rd_data_0};

  cmm_seq_skid #(.W(BEAT_W)) u_skid (
    .clk         (clk),
    .reset       (reset),
    .push        (rd_pending),
    .din         (skid_in),
    .pop         (s_axis_tready),
    .valid       (skid_valid),
    .dout        (skid_out),
    .almost_full (skid_afull)
  );

  assign s_axis_tvalid      = skid_valid;
  assign s_axis_tuser       = skid_out[BEAT_W-1];
  assign s_axis_tlast       = skid_out[BEAT_W-2];
  assign channel_3_base     = skid_out[4*SAMPLE_W-1:3*SAMPLE_W];
  assign channel_2_base     = skid_out[3*SAMPLE_W-1:2*SAMPLE_W];
  assign channel_1_base     = skid_out[2*SAMPLE_W-1:SAMPLE_W];
  assign channel_0_base     = skid_out[SAMPLE_W-1:0];
  assign buf_rd_addr        = rd_addr;
  assign m_axis_dout_tready = dout_ready_q;

  always_comb begin
    state_nxt    = state;
    buf_rd_en    = 1'b0;
    rd_addr      = addr;
    busy         = (state != IDLE);
    done         = 1'b0;
    result_latch = 1'b0;
    case (state)
      IDLE: begin
        rd_addr = '0;
        if (start_acc) begin
          state_nxt = STREAM;
          buf_rd_en = 1'b1;
        end
      end
      STREAM: begin
        buf_rd_en = !reset && !reads_done && !skid_afull;
        if (beat_acc && s_axis_tlast) state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (m_axis_dout_tvalid) begin
          result_latch = 1'b1;
          state_nxt    = DONE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      reads_done   <= 1'b0;
      rd_pending   <= 1'b0;
      pend_user    <= 1'b0;
      pend_last    <= 1'b0;
      tmo_cnt      <= '0;
      err_timeout  <= 1'b0;
      frame_count  <= 16'd0;
      dout_ready_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pending <= buf_rd_en;
      if (buf_rd_en) begin
        pend_user  <= (rd_addr == '0);
        pend_last  <= (rd_addr == LAST_ADDR);
        addr       <= rd_addr + ADDR_W'(1);
        reads_done <= (rd_addr == LAST_ADDR);
      end
      if (start_acc) begin
        err_timeout  <= 1'b0;
        dout_ready_q <= 1'b1;
      end
      if (state == WAIT_RES) begin
        if (!m_axis_dout_tvalid && tmo_cnt == TMO_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (result_latch) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cmm_frame_sequencer.sv
// tb/tb_cmm_frame_sequencer.sv - self-checking bench for cmm_frame_sequencer
module tb_cmm_frame_sequencer;

  localparam int COLS = 256;
  localparam int SW   = 32;
  localparam int AW   = 8;

  typedef struct {
    bit tr_rand;
    int res_delay;
    bit timeout;
    bit start_mid;
    bit stray;
    bit exp_err;
  } row_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, err_timeout;
  logic [15:0]   frame_count;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [SW-1:0] buf_rd_data_0, buf_rd_data_1, buf_rd_data_2, buf_rd_data_3;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic [SW-1:0] channel_0_base, channel_1_base, channel_2_base, channel_3_base;
  logic          m_axis_dout_tvalid, m_axis_dout_tlast, m_axis_dout_tready, result_latch;

  int            n_assert = 0;
  int            n_fail = 0;
  int            beats_seen = 0;
  int            reads = 0;
  bit            tr_rand = 1'b0;
  logic [15:0]   model_fc = 16'd0;
  logic [129:0]  exp_q[$];
  row_t          rows[5];

  cmm_frame_sequencer #(.COLUMNS(COLS), .SAMPLE_W(SW), .ADDR_W(AW), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .frame_count(frame_count),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_rd_data_0(buf_rd_data_0), .buf_rd_data_1(buf_rd_data_1),
    .buf_rd_data_2(buf_rd_data_2), .buf_rd_data_3(buf_rd_data_3),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .channel_0_base(channel_0_base), .channel_1_base(channel_1_base),
    .channel_2_base(channel_2_base), .channel_3_base(channel_3_base),
    .m_axis_dout_tvalid(m_axis_dout_tvalid), .m_axis_dout_tlast(m_axis_dout_tlast),
    .m_axis_dout_tready(m_axis_dout_tready), .result_latch(result_latch)
  );

  always #5 clk = ~clk;

  // Sample buffer: address k holds {k, k+1, k+2, k+3}, one cycle read latency.
  always @(posedge clk) begin
    if (buf_rd_en) begin
      buf_rd_data_0 <= SW'(buf_rd_addr);
      buf_rd_data_1 <= SW'(buf_rd_addr) + 1;
      buf_rd_data_2 <= SW'(buf_rd_addr) + 2;
      buf_rd_data_3 <= SW'(buf_rd_addr) + 3;
    end
  end

  initial begin
    s_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_axis_tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  assign m_axis_dout_tlast = m_axis_dout_tvalid;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [129:0] exp_beat(input int k);
    return {k == 0, k == COLS - 1, 32'(k + 3), 32'(k + 2), 32'(k + 1), 32'(k)};
  endfunction

  // Scoreboard monitor: pops expected beats on each accepted transfer.
  initial begin
    logic [129:0] hold, cur, exp;
    bit hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (buf_rd_en) reads++;
      cur = {s_axis_tuser, s_axis_tlast, channel_3_base, channel_2_base,
             channel_1_base, channel_0_base};
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("tvalid_held_stall", s_axis_tvalid, 1);
          check("payload_stable_stall", cur, hold);
        end
        if (s_axis_tvalid && s_axis_tready) begin
          hold_v = 1'b0;
          beats_seen++;
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("beat_payload", cur, exp);
          end
        end else if (s_axis_tvalid) begin
          hold_v = 1'b1;
          hold = cur;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  task automatic run_frame(input row_t r);
    int cyc;
    bit got_last;
    tr_rand = r.tr_rand;
    m_axis_dout_tvalid = 1'b0;
    beats_seen = 0;
    reads = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < COLS; k++) exp_q.push_back(exp_beat(k));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err_timeout, 0);
    check("dout_tready_after_start", m_axis_dout_tready, 1);
    check("no_beat_1_cycle_after_start", s_axis_tvalid, 0);
    cyc = 1;
    got_last = 1'b0;
    while (!got_last && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) check("first_beat_at_2", s_axis_tvalid, 1);
      start = (r.start_mid && cyc == 50);
      if (r.stray && cyc == 31) begin
        check("no_latch_outside_wait", result_latch, 0);
        m_axis_dout_tvalid = 1'b0;
      end
      if (r.stray && cyc == 30) m_axis_dout_tvalid = 1'b1;
      if (s_axis_tvalid && s_axis_tready && s_axis_tlast) got_last = 1'b1;
    end
    start = 1'b0;
    check("last_beat_seen", got_last, 1);
    if (!r.tr_rand) check("back_to_back_last_cycle", cyc, 257);
    if (r.timeout) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 6000);
      check("timeout_done_cycle", cyc, 4097);
      check("timeout_busy_in_done", busy, 1);
    end else begin
      repeat (r.res_delay) @(posedge clk);
      #1;
      m_axis_dout_tvalid = 1'b1;
      @(negedge clk);
      check("result_latch_pulse", result_latch, 1);
      check("fc_before_latch", frame_count, model_fc);
      @(posedge clk); #1;
      m_axis_dout_tvalid = 1'b0;
      model_fc = model_fc + 16'd1;
      @(negedge clk);
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 1);
      check("latch_one_cycle", result_latch, 0);
    end
    check("frame_count", frame_count, model_fc);
    check("err_timeout", err_timeout, r.exp_err);
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("err_sticky", err_timeout, r.exp_err);
    check("beats_per_frame", beats_seen, COLS);
    check("reads_per_frame", reads, COLS);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rows[0] = '{tr_rand: 0, res_delay: 20, timeout: 0, start_mid: 0, stray: 0, exp_err: 0};
    rows[1] = '{tr_rand: 1, res_delay: 5,  timeout: 0, start_mid: 0, stray: 1, exp_err: 0};
    rows[2] = '{tr_rand: 0, res_delay: 0,  timeout: 1, start_mid: 1, stray: 0, exp_err: 1};
    rows[3] = '{tr_rand: 1, res_delay: 1,  timeout: 0, start_mid: 1, stray: 1, exp_err: 0};
    rows[4] = '{tr_rand: 0, res_delay: 3,  timeout: 0, start_mid: 0, stray: 1, exp_err: 0};

    reset = 1'b1;
    start = 1'b0;
    m_axis_dout_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_fc", frame_count, 0);
    check("rst_tvalid", s_axis_tvalid, 0);
    check("rst_rd_en", buf_rd_en, 0);
    check("rst_rd_addr", buf_rd_addr, 0);
    check("rst_ch0", channel_0_base, 0);
    check("rst_dout_tready", m_axis_dout_tready, 0);
    check("rst_latch", result_latch, 0);

    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_with_reset_idle", busy, 0);
    check("start_with_reset_no_tready", m_axis_dout_tready, 0);

    for (int i = 0; i < 5; i++) run_frame(rows[i]);

    tr_rand = 1'b0;
    beats_seen = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int k = 0; k < COLS; k++) exp_q.push_back(exp_beat(k));
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready && channel_0_base == 32'd100) begin
        reset = 1'b1;
        found = 1'b1;
      end
    end
    check("reached_beat_100", found, 1);
    @(negedge clk);
    check("midreset_tvalid", s_axis_tvalid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_fc", frame_count, 0);
    check("midreset_dout_tready", m_axis_dout_tready, 0);
    check("midreset_beats", beats_seen, 101);
    reset = 1'b0;
    exp_q.delete();
    model_fc = 16'd0;
    run_frame(rows[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
